// File: rtl/uart_tx_engine.sv
// UART transmit engine: loads a byte on a one-cycle load pulse and shifts out an
// 11-bit frame (start, 7/8 data, optional parity, stop padding) at baud_k clocks per bit.
module uart_tx_engine #(
    parameter int unsigned BAUD_WIDTH = 19
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [BAUD_WIDTH-1:0] baud_k,
    input  logic                  eight,
    input  logic                  pen,
    input  logic                  ohel,
    input  logic                  load,
    input  logic [7:0]            out_port,
    output logic                  tx,
    output logic                  busy,
    output logic                  tx_done
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;

    logic [0:0]            state_q, state_d;
    logic [10:0]           sr_q, sr_d;
    logic [BAUD_WIDTH-1:0] kmax_q, kmax_d;
    logic [BAUD_WIDTH-1:0] cnt_q, cnt_d;
    logic [3:0]            nbit_q, nbit_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic                  parity;
    logic [10:0]           frame;
    logic [BAUD_WIDTH-1:0] kmax_in;

    // Parity covers only the data bits actually sent; odd sense inverts it.
    always_comb begin
        parity = (eight ? (^out_port) : (^out_port[6:0])) ^ ohel;
        if (eight)
            frame = {1'b1, (pen ? parity : 1'b1), out_port, 1'b0};
        else
            frame = {2'b11, (pen ? parity : 1'b1), out_port[6:0], 1'b0};
        kmax_in = (baud_k == '0) ? '0 : baud_k - BAUD_WIDTH'(1);
    end

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        kmax_d  = kmax_q;
        cnt_d   = cnt_q;
        nbit_d  = nbit_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (load) begin
                    sr_d    = frame;
                    kmax_d  = kmax_in;
                    cnt_d   = '0;
                    nbit_d  = '0;
                    busy_d  = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (cnt_q == kmax_q) begin
                    cnt_d = '0;
                    sr_d  = {1'b1, sr_q[10:1]};
                    if (nbit_q == 4'd10) begin
                        nbit_d  = '0;
                        sr_d    = '1;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        nbit_d = nbit_q + 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q + BAUD_WIDTH'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            sr_q    <= '1;
            kmax_q  <= '0;
            cnt_q   <= '0;
            nbit_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            kmax_q  <= kmax_d;
            cnt_q   <= cnt_d;
            nbit_q  <= nbit_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign tx      = sr_q[0];
    assign busy    = busy_q;
    assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Bench for uart_tx_engine: fixed frame table, hand-written corner sequences and
// random frames checked cycle by cycle against a frame-level reference model.
module tb_uart_tx_engine;

    localparam int unsigned BW = 19;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [BW-1:0] baud_k = '0;
    logic          eight = 1'b0, pen = 1'b0, ohel = 1'b0, load = 1'b0;
    logic [7:0]    out_port = '0;
    logic          tx, busy, tx_done;

    int n_cmp = 0;
    int n_err = 0;

    uart_tx_engine #(.BAUD_WIDTH(BW)) dut (
        .clk(clk), .reset(reset), .baud_k(baud_k), .eight(eight), .pen(pen),
        .ohel(ohel), .load(load), .out_port(out_port),
        .tx(tx), .busy(busy), .tx_done(tx_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [BW-1:0] bk;
        logic          e, p, o;
        logic [7:0]    d;
        logic [10:0]   fr;   // expected line bits, bit i = i-th bit on the wire
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string nm, input logic [2:0] got, input logic [2:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: tx/busy/done got %b required %b", nm, got, exp);
        end
    endtask

    // Reference: list the wire bits in order, then pad with idle ones to 11.
    function automatic logic [10:0] model_frame(input logic e, input logic p,
                                                input logic o, input logic [7:0] d);
        logic q[$];
        logic par;
        logic [10:0] r;
        int nb;
        nb  = e ? 8 : 7;
        par = o;
        q.push_back(1'b0);
        for (int i = 0; i < nb; i++) begin
            q.push_back(d[i]);
            par = par ^ d[i];
        end
        if (p) q.push_back(par);
        while (q.size() < 11) q.push_back(1'b1);
        for (int i = 0; i < 11; i++) r[i] = q[i];
        return r;
    endfunction

    function automatic int keff(input logic [BW-1:0] bk);
        return (bk == '0) ? 1 : int'(bk);
    endfunction

    // Called at a negedge; returns at the negedge inside the first frame cycle.
    task automatic start(input logic [BW-1:0] bk, input logic e, input logic p,
                         input logic o, input logic [7:0] d);
        baud_k = bk; eight = e; pen = p; ohel = o; out_port = d; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    // Checks every cycle of a frame plus the done cycle; optionally pulses a
    // disruptive load with altered configuration at cycle glitch_at.
    task automatic expect_frame(input string nm, input int k, input logic [10:0] fr,
                                input int glitch_at);
        for (int c = 0; c < 11 * k; c++) begin
            chk($sformatf("%s cyc%0d", nm, c), {tx, busy, tx_done}, {fr[c / k], 2'b10});
            if (c == glitch_at) begin
                load = 1'b1; out_port = ~out_port; eight = ~eight; pen = ~pen;
                baud_k = BW'(7);
            end else begin
                load = 1'b0;
            end
            @(negedge clk);
        end
        load = 1'b0;
        chk($sformatf("%s done", nm), {tx, busy, tx_done}, 3'b101);
    endtask

    task automatic idle_check(input string nm, input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            chk($sformatf("%s idle%0d", nm, c), {tx, busy, tx_done}, 3'b100);
        end
    endtask

    initial begin
        tbl[0] = '{bk: BW'(4), e: 1'b1, p: 1'b1, o: 1'b0, d: 8'hA5, fr: 11'b1_0_10100101_0};
        tbl[1] = '{bk: BW'(4), e: 1'b1, p: 1'b1, o: 1'b1, d: 8'hA5, fr: 11'b1_1_10100101_0};
        tbl[2] = '{bk: BW'(1), e: 1'b0, p: 1'b0, o: 1'b0, d: 8'hC1, fr: 11'b1_1_1_1000001_0};
        tbl[3] = '{bk: BW'(2), e: 1'b0, p: 1'b1, o: 1'b1, d: 8'h55, fr: 11'b1_1_1_1010101_0};
        tbl[4] = '{bk: BW'(0), e: 1'b1, p: 1'b0, o: 1'b0, d: 8'h3C, fr: 11'b1_1_00111100_0};
        tbl[5] = '{bk: BW'(3), e: 1'b1, p: 1'b1, o: 1'b0, d: 8'h01, fr: 11'b1_1_00000001_0};

        // Reset state, then quiet idle line.
        @(negedge clk);
        chk("reset held", {tx, busy, tx_done}, 3'b100);
        reset = 1'b0;
        idle_check("post-reset", 20);

        foreach (tbl[i]) begin
            start(tbl[i].bk, tbl[i].e, tbl[i].p, tbl[i].o, tbl[i].d);
            expect_frame($sformatf("tbl%0d", i), keff(tbl[i].bk), tbl[i].fr, -1);
            idle_check($sformatf("tbl%0d", i), 2);
        end

        // Load held high for several idle cycles starts a single frame.
        baud_k = BW'(1); eight = 1'b1; pen = 1'b0; ohel = 1'b0; out_port = 8'h0F; load = 1'b1;
        @(negedge clk);
        for (int c = 0; c < 11; c++) begin
            chk($sformatf("held-load cyc%0d", c), {tx, busy, tx_done},
                {model_frame(1'b1, 1'b0, 1'b0, 8'h0F) >> c, 2'b10} & 3'b110 | {2'b01, 1'b0} & 3'b010);
            if (c == 3) load = 1'b0;
            @(negedge clk);
        end
        chk("held-load done", {tx, busy, tx_done}, 3'b101);
        idle_check("held-load", 3);

        // Back-to-back: ignored mid-frame load, then reload in the done cycle.
        start(BW'(2), 1'b1, 1'b0, 1'b0, 8'h55);
        expect_frame("b2b first", 2, 11'b1_1_01010101_0, 6);
        start(BW'(2), 1'b1, 1'b0, 1'b0, 8'h33);
        expect_frame("b2b second", 2, 11'b1_1_00110011_0, -1);
        idle_check("b2b", 2);

        // Reset during bit 5 abandons the frame with no done pulse.
        start(BW'(3), 1'b1, 1'b1, 1'b0, 8'hFF);
        repeat (5 * 3 + 1) @(negedge clk);
        chk("mid-frame busy", {tx, busy, tx_done}, 3'b110);
        #2 reset = 1'b1;
        #1 chk("async reset", {tx, busy, tx_done}, 3'b100);
        @(negedge clk);
        reset = 1'b0;
        idle_check("after reset", 40);
        start(BW'(3), 1'b1, 1'b1, 1'b0, 8'hFF);
        expect_frame("after reset FF", 3, 11'b1_0_11111111_0, -1);

        // Random frames against the reference model.
        for (int n = 0; n < 40; n++) begin
            logic [BW-1:0] bk;
            logic e, p, o;
            logic [7:0] d;
            int g;
            bk = BW'($urandom_range(4, 0));
            e = 1'($urandom); p = 1'($urandom); o = 1'($urandom); d = 8'($urandom);
            g = ($urandom_range(1, 0) == 1) ? int'($urandom_range(10 * keff(bk), 1)) : -1;
            start(bk, e, p, o, d);
            expect_frame($sformatf("rnd%0d", n), keff(bk), model_frame(e, p, o, d), g);
            if ($urandom_range(2, 0) != 0)
                idle_check($sformatf("rnd%0d", n), int'($urandom_range(3, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
